// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares one single-port data memory between the core load/store port and an
// external loader/debug port. Requests are arbitrated round-robin in IDLE; the
// winner's address, data and direction are registered onto the mem_* lines,
// and the access is sequenced through ISSUE -> (WAIT) -> RESP with a
// fixed read latency of MEM_LAT cycles after the enable cycle.
//
// Parameters
//   DATA_W   data word width
//   ADDR_W   word address width
//   MEM_LAT  memory read latency after the mem_en cycle (1..7)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   core_rd/core_wr            core load/store request, held until core_done
//   core_addr/core_wdata       core word address / store data
//   core_rdata                 core load data, held until the next core read
//   core_done                  one-cycle core completion pulse
//   core_stall                 combinational pipeline freeze
//   ext_req/ext_we             external request / direction (1 = write)
//   ext_addr/ext_wdata         external word address / write data
//   ext_rdata                  external read data, held
//   ext_gnt                    external side owns the memory (ISSUE..RESP)
//   ext_done                   one-cycle external completion pulse
//   mem_en/mem_we              memory enable (ISSUE only) / write enable
//   mem_addr/mem_wdata         registered memory address / write data
//   mem_rdata                  memory read data, MEM_LAT cycles after mem_en
module dmem_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  // Core load/store port
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_done,
  output logic              core_stall,
  // External loader/debug port
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_gnt,
  output logic              ext_done,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  typedef enum logic {
    OwnCore = 1'b0,
    OwnExt  = 1'b1
  } owner_e;

  // WAIT counts down from MEM_LAT-1 so the capture lands in cycle 1+MEM_LAT.
  localparam logic [2:0] CntLoad = 3'(MEM_LAT - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                core_done_q, core_done_d;
  logic                ext_done_q, ext_done_d;
  logic                ext_gnt_q, ext_gnt_d;

  logic                core_req;
  logic                pick_ext;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_rdata_d = core_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    core_done_d  = 1'b0;
    ext_done_d   = 1'b0;
    ext_gnt_d    = ext_gnt_q;

    core_req = core_rd | core_wr;
    // Ext wins outright when alone, or on a tie when the core was served last.
    pick_ext = ext_req & (~core_req | (last_owner_q == OwnCore));

    unique case (state_q)
      StIdle: begin
        if (core_req || ext_req) begin
          owner_d      = pick_ext ? OwnExt : OwnCore;
          last_owner_d = pick_ext ? OwnExt : OwnCore;
          mem_en_d     = 1'b1;
          // A core request with both rd and wr set is a store.
          mem_we_d     = pick_ext ? ext_we : core_wr;
          mem_addr_d   = pick_ext ? ext_addr : core_addr;
          mem_wdata_d  = pick_ext ? ext_wdata : core_wdata;
          ext_gnt_d    = pick_ext;
          state_d      = StIssue;
        end
      end

      StIssue: begin
        if (mem_we_q) begin
          core_done_d = (owner_q == OwnCore);
          ext_done_d  = (owner_q == OwnExt);
          state_d     = StResp;
        end else begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end
      end

      StWait: begin
        if (cnt_q == 3'd0) begin
          // Only the owner's read register moves; the other side holds.
          if (owner_q == OwnExt) begin
            ext_rdata_d = mem_rdata;
          end else begin
            core_rdata_d = mem_rdata;
          end
          core_done_d = (owner_q == OwnCore);
          ext_done_d  = (owner_q == OwnExt);
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      StResp: begin
        // No re-arbitration here: the requester's lines are still stale.
        ext_gnt_d = 1'b0;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnExt;
      last_owner_q <= OwnExt;
      cnt_q        <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      core_done_q  <= 1'b0;
      ext_done_q   <= 1'b0;
      ext_gnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
      core_done_q  <= core_done_d;
      ext_done_q   <= ext_done_d;
      ext_gnt_q    <= ext_gnt_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rdata = core_rdata_q;
  assign core_done  = core_done_q;
  assign ext_rdata  = ext_rdata_q;
  assign ext_done   = ext_done_q;
  assign ext_gnt    = ext_gnt_q;

  assign core_stall = (core_rd | core_wr) & ~core_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard of expected memory grants and
// completions, a latency-accurate memory model, and directed timing checks.
module tb_dmem_arbiter;

  localparam int DataW  = 32;
  localparam int AddrW  = 9;
  localparam int MemLat = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             core_rd = 1'b0, core_wr = 1'b0;
  logic [AddrW-1:0] core_addr = '0;
  logic [DataW-1:0] core_wdata = '0;
  logic [DataW-1:0] core_rdata;
  logic             core_done, core_stall;
  logic             ext_req = 1'b0, ext_we = 1'b0;
  logic [AddrW-1:0] ext_addr = '0;
  logic [DataW-1:0] ext_wdata = '0;
  logic [DataW-1:0] ext_rdata;
  logic             ext_gnt, ext_done;
  logic             mem_en, mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W (DataW),
    .ADDR_W (AddrW),
    .MEM_LAT(MemLat)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_done (core_done),
    .core_stall(core_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_gnt   (ext_gnt),
    .ext_done  (ext_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: data only valid exactly MemLat cycles after the enable cycle.
  logic [DataW-1:0] mem_model [512];
  logic [DataW-1:0] ref_mem   [512];
  logic [DataW-1:0] pipe_d    [1:MemLat];
  logic             pipe_v    [1:MemLat];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
    pipe_v[1] <= mem_en && !mem_we;
    pipe_d[1] <= mem_model[mem_addr];
    for (int k = 2; k <= MemLat; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
  end

  assign mem_rdata = (pipe_v[MemLat] === 1'b1) ? pipe_d[MemLat] : 32'hBADC_0FFE;

  // Scoreboard
  typedef struct packed {
    logic             ext;
    logic             we;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
    logic [DataW-1:0] rdata;
  } txn_t;

  txn_t grant_q[$];
  txn_t done_q[$];
  logic [DataW-1:0] exp_core_rdata = '0;
  logic [DataW-1:0] exp_ext_rdata  = '0;

  // Push in predicted grant order; ref_mem tracks the expected memory image.
  task automatic expect_txn(input logic ext, input logic we, input logic [AddrW-1:0] a,
                            input logic [DataW-1:0] d);
    txn_t t;
    t.ext   = ext;
    t.we    = we;
    t.addr  = a;
    t.wdata = d;
    t.rdata = we ? '0 : ref_mem[a];
    if (we) ref_mem[a] = d;
    grant_q.push_back(t);
  endtask

  always @(negedge clk) begin
    txn_t e;
    if (!reset) begin
      if (mem_en) begin
        check_eq("grant_expected", 32'(grant_q.size() != 0), 32'd1);
        if (grant_q.size() != 0) begin
          e = grant_q.pop_front();
          check_eq("gnt_owner", ext_gnt, e.ext);
          check_eq("mem_we", mem_we, e.we);
          check_eq("mem_addr", mem_addr, e.addr);
          if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
          done_q.push_back(e);
        end
      end
      if (core_done || ext_done) begin
        check_eq("done_excl", core_done & ext_done, 1'b0);
        check_eq("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          e = done_q.pop_front();
          check_eq("done_side", ext_done, e.ext);
          if (!e.we) begin
            if (e.ext) exp_ext_rdata = e.rdata;
            else exp_core_rdata = e.rdata;
          end
          check_eq("core_rdata", core_rdata, exp_core_rdata);
          check_eq("ext_rdata", ext_rdata, exp_ext_rdata);
        end
      end
    end
  end

  // Cycle 0 is the cycle in which the request lines are first driven.
  task automatic core_txn(input logic rd, input logic wr, input logic [AddrW-1:0] a,
                          input logic [DataW-1:0] d, output int lat, output int en_cyc);
    core_rd = rd; core_wr = wr; core_addr = a; core_wdata = d;
    lat = -1; en_cyc = -1;
    for (int i = 0; i < 64 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_en && !ext_gnt && en_cyc < 0) en_cyc = i;
      if (core_done) begin
        lat = i;
        check_eq("core_stall_done", core_stall, 1'b0);
      end else begin
        check_eq("core_stall_wait", core_stall, 1'b1);
      end
    end
    check_eq("core_timeout", 32'(lat >= 0), 32'd1);
    @(posedge clk); #1;
    core_rd = 1'b0; core_wr = 1'b0;
  endtask

  task automatic ext_txn(input logic we, input logic [AddrW-1:0] a, input logic [DataW-1:0] d,
                         output int lat, output int gnt_cyc);
    ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
    lat = -1; gnt_cyc = -1;
    for (int i = 0; i < 64 && lat < 0; i++) begin
      @(negedge clk);
      if (ext_gnt && gnt_cyc < 0) gnt_cyc = i;
      if (ext_done) lat = i;
    end
    check_eq("ext_timeout", 32'(lat >= 0), 32'd1);
    @(posedge clk); #1;
    ext_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {27'd0, mem_en, mem_we, core_done, ext_done, ext_gnt}, 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_core_rdata"}, core_rdata, 32'd0);
    check_eq({tag, "_ext_rdata"}, ext_rdata, 32'd0);
  endtask

  initial begin
    int lat, en, lat2, gnt2, dummy;
    for (int i = 0; i < 512; i++) begin
      mem_model[i] = 32'h0101_0101 * i ^ 32'h5A5A_0000;
      ref_mem[i]   = 32'h0101_0101 * i ^ 32'h5A5A_0000;
    end

    // Reset state; core_stall is combinational and follows its inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check_eq("stall_idle_reset", core_stall, 1'b0);
    core_rd = 1'b1;
    #1 check_eq("stall_follows_input", core_stall, 1'b1);
    core_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Core store
    expect_txn(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF);
    core_txn(1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, lat, en);
    check_eq("store_en_cycle", en, 1);
    check_eq("store_done_cycle", lat, 2);

    // Core load
    expect_txn(1'b0, 1'b0, 9'h010, '0);
    core_txn(1'b1, 1'b0, 9'h010, '0, lat, en);
    check_eq("load_en_cycle", en, 1);
    check_eq("load_done_cycle", lat, 2 + MemLat);
    check_eq("load_data", core_rdata, 32'hDEAD_BEEF);

    // External write/read at the top address
    expect_txn(1'b1, 1'b1, 9'h1FF, 32'h1234_5678);
    ext_txn(1'b1, 9'h1FF, 32'h1234_5678, lat, gnt2);
    check_eq("ext_wr_done_cycle", lat, 2);
    check_eq("ext_wr_gnt_cycle", gnt2, 1);
    expect_txn(1'b1, 1'b0, 9'h1FF, '0);
    ext_txn(1'b0, 9'h1FF, '0, lat, gnt2);
    check_eq("ext_rd_done_cycle", lat, 2 + MemLat);

    // rd and wr together is a store
    expect_txn(1'b0, 1'b1, 9'h000, 32'hCAFE_F00D);
    core_txn(1'b1, 1'b1, 9'h000, 32'hCAFE_F00D, lat, en);
    check_eq("rdwr_done_cycle", lat, 2);
    expect_txn(1'b0, 1'b0, 9'h000, '0);
    core_txn(1'b1, 1'b0, 9'h000, '0, lat, en);

    // Reset while a core read sits in WAIT
    expect_txn(1'b0, 1'b0, 9'h020, '0);
    core_rd = 1'b1; core_addr = 9'h020;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    core_rd = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("reset_wait");
    reset = 1'b0;
    grant_q.delete();
    done_q.delete();
    exp_core_rdata = '0;
    exp_ext_rdata  = '0;
    repeat (6) begin
      @(negedge clk);
      check_eq("quiet_after_reset", {29'd0, core_done, ext_done, mem_en}, 32'd0);
    end
    @(posedge clk); #1;

    // Tie after reset: core first, ext next
    expect_txn(1'b0, 1'b0, 9'h010, '0);
    expect_txn(1'b1, 1'b0, 9'h1FF, '0);
    fork
      core_txn(1'b1, 1'b0, 9'h010, '0, lat, en);
      ext_txn(1'b0, 9'h1FF, '0, lat2, gnt2);
    join
    check_eq("tie_core_done", lat, 2 + MemLat);
    check_eq("tie_ext_gnt", gnt2, 4 + MemLat);
    check_eq("tie_ext_done", lat2, 5 + 2 * MemLat);

    // Sustained contention: grants alternate C, E, C, E
    expect_txn(1'b0, 1'b1, 9'h030, 32'h1111_1111);
    expect_txn(1'b1, 1'b0, 9'h030, '0);
    expect_txn(1'b0, 1'b0, 9'h1FF, '0);
    expect_txn(1'b1, 1'b1, 9'h005, 32'h55AA_55AA);
    fork
      begin
        int l_a, e_a;
        core_txn(1'b0, 1'b1, 9'h030, 32'h1111_1111, l_a, e_a);
        core_txn(1'b1, 1'b0, 9'h1FF, '0, l_a, e_a);
      end
      begin
        int l_b, g_b;
        ext_txn(1'b0, 9'h030, '0, l_b, g_b);
        ext_txn(1'b1, 9'h005, 32'h55AA_55AA, l_b, g_b);
      end
    join
    check_eq("contention_ext_rdata", ext_rdata, 32'h1111_1111);
    check_eq("contention_core_rdata", core_rdata, 32'h1234_5678);

    expect_txn(1'b0, 1'b0, 9'h005, '0);
    core_txn(1'b1, 1'b0, 9'h005, '0, lat, dummy);
    check_eq("ext_write_visible", core_rdata, 32'h55AA_55AA);

    repeat (3) @(posedge clk);
    check_eq("grants_drained", grant_q.size(), 0);
    check_eq("dones_drained", done_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
